// File: rtl/sync_fifo_rd_stream.sv
// sync_fifo_rd_stream: synchronous FIFO with a push write side and a
// registered first-word-fall-through valid/ready read side.
// Capacity is DEPTH memory entries plus the output register (DEPTH+1 total).
// When mem is empty and the output register needs a new entry, a push goes
// straight into the output register and the memory is not written.
// Optional feature macro: FIFO_OVF_FLAG_EN adds a sticky ovf flag (ports ovf,
// ovf_clr) recording pushes attempted while full.
module sync_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int COUNT_W    = $clog2(DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
`ifdef FIFO_OVF_FLAG_EN
  output logic                  ovf,
  input  logic                  ovf_clr,
`endif
  output logic [COUNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  mem_we;

  logic push, pop, load, mem_empty;

  // Full is decoded from the registered count, so it never depends on inputs.
  assign full      = (count_q == COUNT_W'(DEPTH + 1));
  assign push      = wr_en && !full;
  assign pop       = rd_valid_q && rd_ready;
  assign load      = !rd_valid_q || pop;
  // Memory occupancy is count minus the entry sitting in the output register.
  assign mem_empty = (count_q == COUNT_W'(rd_valid_q));

  // Next-state: output register refill, pointer advance, occupancy count.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    mem_we     = 1'b0;

    if (load) begin
      if (!mem_empty) begin
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        if (push) mem_we = 1'b1;
      end else if (push) begin
        rd_data_d  = wr_data;
        rd_valid_d = 1'b1;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else if (push) begin
      mem_we = 1'b1;
    end

    if (mem_we) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + COUNT_W'(1);
    else if (pop && !push) count_d = count_q - COUNT_W'(1);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;

`ifdef FIFO_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && full) ovf_d = 1'b1;
    else if (ovf_clr)  ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule
